// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the RV32I data port. Accepts one load/store at a
// time, waits WAIT_CYCLES cycles, then performs the access against an internal
// little-endian word array and returns a response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge; ready
// may change freely and is never a function of valid in this block.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder can accept (IDLE only)
//   req_we     : 1 = store, 0 = load
//   req_func3  : 0 b, 1 h, 2 w, 4 bu, 5 hu
//   req_addr   : byte address
//   req_wdata  : right-aligned store data
//   rsp_valid  : response present
//   rsp_ready  : initiator consumes the response
//   rsp_rdata  : extended load data, 0 for stores and errors
//   rsp_err    : request rejected, no memory update
//   dbg_state  : current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Access decode on the latched request
  // ---------------------------------------------------------------------------
  logic [AW-1:0] word_idx;
  logic [31:0]   word_hi;
  logic          range_err;
  logic          func_err;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_data;
  logic [31:0]   wr_word;
  logic          mem_we;

  assign word_idx = addr_q[AW+1:2];
  // DEPTH_WORDS is a power of two, so any set bit above the index is out of range.
  assign word_hi   = addr_q >> (AW + 2);
  assign range_err = |word_hi;
  assign rd_word   = mem[word_idx];

  always_comb begin
    func_err = 1'b0;
    case (func3_q)
      3'd0:    func_err = 1'b0;
      3'd1:    func_err = addr_q[0];
      3'd2:    func_err = (addr_q[1:0] != 2'b00);
      3'd4:    func_err = we_q;
      3'd5:    func_err = we_q | addr_q[0];
      default: func_err = 1'b1;
    endcase
  end

  assign acc_err = func_err | range_err;

  always_comb begin
    lane_b = rd_word[7:0];
    case (addr_q[1:0])
      2'd0: lane_b = rd_word[7:0];
      2'd1: lane_b = rd_word[15:8];
      2'd2: lane_b = rd_word[23:16];
      2'd3: lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = 32'd0;
    case (func3_q)
      3'd0:    load_data = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_data = {{16{lane_h[15]}}, lane_h};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, lane_b};
      3'd5:    load_data = {16'd0, lane_h};
      default: load_data = 32'd0;
    endcase
  end

  // Read-modify-write merge: only the addressed lane changes.
  always_comb begin
    wr_word = rd_word;
    case (func3_q[1:0])
      2'd0: begin
        case (addr_q[1:0])
          2'd0: wr_word[7:0]   = wdata_q[7:0];
          2'd1: wr_word[15:8]  = wdata_q[7:0];
          2'd2: wr_word[23:16] = wdata_q[7:0];
          2'd3: wr_word[31:24] = wdata_q[7:0];
          default: wr_word = rd_word;
        endcase
      end
      2'd1: begin
        if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        // The <= guard keeps a zero count from wrapping to 15.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          // First RESP edge: the access itself. rsp_ready is not looked at yet.
          rsp_valid_d = 1'b1;
          err_d       = acc_err;
          rdata_d     = (acc_err || we_q) ? 32'd0 : load_data;
          mem_we      = we_q && !acc_err;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rdata_d     = 32'd0;
          err_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
        cnt_d       = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      func3_q     <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Array contents survive reset; mem_we is only raised outside reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two responder instances share the request payload: u_dut_w2 (WAIT_CYCLES=2)
// and u_dut_w0 (WAIT_CYCLES=0). sel_zero routes req_valid/rsp_ready to one of
// them and muxes its outputs back. Expected {err, rdata} values come from a
// reference memory model and are queued at issue time, popped at response.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic        sel_zero;
  logic        req_valid;
  logic        rsp_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // Per-instance outputs
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_state;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  logic [1:0]  z_state;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dut_state;

  assign req_ready = sel_zero ? z_req_ready : a_req_ready;
  assign rsp_valid = sel_zero ? z_rsp_valid : a_rsp_valid;
  assign rsp_err   = sel_zero ? z_rsp_err   : a_rsp_err;
  assign rsp_rdata = sel_zero ? z_rsp_rdata : a_rsp_rdata;
  assign dut_state = sel_zero ? z_state     : a_state;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) u_dut_w2 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & ~sel_zero),
    .req_ready (a_req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready & ~sel_zero),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .dbg_state (a_state)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & sel_zero),
    .req_ready (z_req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (rsp_ready & sel_zero),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err),
    .dbg_state (z_state)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_mem [2][DEPTH];

  // Reference model
  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    if ({2'b00, a[31:2]} >= 32'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    w  = model_mem[sel_zero][a[9:2]];
    sh = w >> (8 * a[1:0]);
    b  = sh[7:0];
    sh = w >> (16 * a[1]);
    h  = sh[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = model_mem[sel_zero][a[9:2]];
    if (f3 == 3'd0)      w[8*a[1:0] +: 8] = d[7:0];
    else if (f3 == 3'd1) w[16*a[1] +: 16] = d[15:0];
    else                 w = d;
    model_mem[sel_zero][a[9:2]] = w;
  endtask

  // Push expectation and update the model for one request.
  task automatic expect_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d);
    if (model_err(we, f3, a))  exp_q.push_back({1'b1, 32'd0});
    else if (we) begin
      exp_q.push_back({1'b0, 32'd0});
      model_store(f3, a, d);
    end else exp_q.push_back({1'b0, model_load(f3, a)});
  endtask

  // Driver tasks
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
    int n;
    @(negedge clk);
    req_we = we; req_func3 = f3; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready stayed %0b, required 1", req_ready);
    end
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int acc);
    int n;
    int lat;
    logic [32:0] exp;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%0b, required 1", name, rsp_valid);
    end
    lat = cyc - acc;
    checks++;
    if (lat !== (sel_zero ? 1 : WAITS + 1)) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, sel_zero ? 1 : WAITS + 1);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    checks++;
    if ({rsp_err, rsp_rdata} !== exp) begin
      errors++;
      $display("FAIL %s_data: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
               name, rsp_err, rsp_rdata, exp[32], exp[31:0]);
    end
  endtask

  task automatic release_rsp(input string name);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL %s_release: req_ready=%0b rsp_valid=%0b rdata=%08h, required 1 0 00000000",
               name, req_ready, rsp_valid, rsp_rdata);
    end
  endtask

  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input string name);
    int acc;
    expect_req(we, f3, a, d);
    issue(we, f3, a, d, acc);
    wait_rsp(name, acc);
    release_rsp(name);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 ||
        a_rsp_err !== 1'b0 || a_state !== 2'd0) begin
      errors++;
      $display("FAIL %s_w2: ready=%0b valid=%0b rdata=%08h err=%0b state=%0d, required 1 0 00000000 0 0",
               name, a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_state);
    end
    checks++;
    if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rsp_rdata !== 32'd0 ||
        z_rsp_err !== 1'b0 || z_state !== 2'd0) begin
      errors++;
      $display("FAIL %s_w0: ready=%0b valid=%0b rdata=%08h err=%0b state=%0d, required 1 0 00000000 0 0",
               name, z_req_ready, z_rsp_valid, z_rsp_rdata, z_rsp_err, z_state);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b0;
    sel_zero = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
  endtask

  task automatic test_basic();
    xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10");
    xact(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
  endtask

  task automatic test_subword();
    xact(1'b1, 3'd2, 32'h80, 32'h80F17F01, "sw_80");
    xact(1'b0, 3'd0, 32'h83, 32'h0, "lb_83");
    xact(1'b0, 3'd4, 32'h83, 32'h0, "lbu_83");
    xact(1'b0, 3'd1, 32'h82, 32'h0, "lh_82");
    xact(1'b0, 3'd5, 32'h82, 32'h0, "lhu_82");
    xact(1'b0, 3'd0, 32'h81, 32'h0, "lb_81");
    xact(1'b0, 3'd1, 32'h80, 32'h0, "lh_80");
  endtask

  task automatic test_lanes();
    xact(1'b1, 3'd2, 32'h20, 32'h11223344, "sw_20");
    xact(1'b1, 3'd0, 32'h21, 32'hFFFFFFAA, "sb_21");
    xact(1'b1, 3'd1, 32'h22, 32'hFFFFBBCC, "sh_22");
    xact(1'b0, 3'd2, 32'h20, 32'h0, "lw_20");
  endtask

  task automatic test_errors();
    xact(1'b1, 3'd2, 32'h04, 32'h5A5AA5A5, "sw_04");
    xact(1'b0, 3'd2, 32'h04, 32'h0, "lw_04_before");
    xact(1'b0, 3'd2, 32'h02, 32'h0, "err_lw_02");
    xact(1'b1, 3'd1, 32'h05, 32'h0000FFFF, "err_sh_05");
    xact(1'b1, 3'd4, 32'h04, 32'h000000EE, "err_sb_f4");
    xact(1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, "err_lw_oob");
    xact(1'b0, 3'd3, 32'h04, 32'h0, "err_f3");
    xact(1'b0, 3'd7, 32'h04, 32'h0, "err_f7");
    xact(1'b0, 3'd2, 32'h04, 32'h0, "lw_04_after");
  endtask

  task automatic test_backpressure();
    int acc;
    logic [31:0] held;
    expect_req(1'b0, 3'd2, 32'h10, 32'h0);
    expect_req(1'b0, 3'd2, 32'h80, 32'h0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, acc);
    wait_rsp("bp_first", acc);
    held = rsp_rdata;
    req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h80; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0 || dut_state !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b rdata=%08h ready=%0b state=%0d, required 1 %08h 0 2",
                 i, rsp_valid, rsp_rdata, req_ready, dut_state, held);
      end
    end
    release_rsp("bp_first");
    @(posedge clk);
    #1 acc = cyc;
    checks++;
    if (dut_state !== 2'd1) begin
      errors++;
      $display("FAIL bp_second_accept: state=%0d, required 1", dut_state);
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp("bp_second", acc);
    release_rsp("bp_second");
  endtask

  task automatic test_ready_early();
    rsp_ready = 1'b1;
    xact(1'b0, 3'd2, 32'h20, 32'h0, "early_ready");
  endtask

  task automatic test_reset_mid();
    int acc;
    int n;
    xact(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, "sw_30_prior");
    // Dropped store: no expectation, model untouched.
    issue(1'b1, 3'd2, 32'h30, 32'h12345678, acc);
    checks++;
    if (dut_state !== 2'd1) begin
      errors++;
      $display("FAIL rst_wait_state: state=%0d, required 1", dut_state);
    end
    rst = 1'b0;
    #1 check_reset_outputs("rst_in_wait");
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 3'd2, 32'h30, 32'h0, "lw_30_after_rst");

    // Reset while the response is held: the store already landed.
    model_store(3'd2, 32'h34, 32'h55667788);
    issue(1'b1, 3'd2, 32'h34, 32'h55667788, acc);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1 check_reset_outputs("rst_in_resp");
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 3'd2, 32'h34, 32'h0, "lw_34_after_rst");
  endtask

  task automatic test_zero_wait();
    sel_zero = 1'b1;
    xact(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, "w0_sw_30");
    xact(1'b0, 3'd2, 32'h30, 32'h0, "w0_lw_30");
    xact(1'b1, 3'd0, 32'h32, 32'h00000099, "w0_sb_32");
    xact(1'b0, 3'd0, 32'h32, 32'h0, "w0_lb_32");
    xact(1'b0, 3'd5, 32'h32, 32'h0, "w0_lhu_32");
    xact(1'b0, 3'd2, 32'h31, 32'h0, "w0_err_lw_31");
    xact(1'b0, 3'd2, 32'h30, 32'h0, "w0_lw_30_again");
    sel_zero = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  f3;
    bit          we;
    for (int i = 0; i < 16; i++)
      xact(1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom, "rnd_init");
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a + 32'(DEPTH * 4);
      xact(we, f3, a, $urandom, "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subword();
    test_lanes();
    test_errors();
    test_backpressure();
    test_ready_early();
    test_reset_mid();
    test_zero_wait();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
